// File: rtl/alien_march_sequencer_pkg.sv
// Shared types and defaults for the alien march sequencer.
package alien_march_sequencer_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_MARCH,
        M_DONE
    } march_t;

    localparam int DEF_STEP_X  = 2;
    localparam int DEF_STEP_Y  = 8;
    localparam int FRAME_CNT_W = 6;

endpackage

// File: rtl/alien_march_sequencer_if.sv
// Bus between game_state / alien datapath (master) and the march sequencer (slave).
interface alien_march_sequencer_if #(
    parameter int NUM_ALIENS = 40
);
    localparam int AW = $clog2(NUM_ALIENS + 1);

    logic                 frame_tick;
    logic                 run;
    logic                 restart;
    logic [AW-1:0]        alive_count;
    logic                 hit_left;
    logic                 hit_right;
    logic                 hit_bottom;
    logic                 step_valid;
    logic signed [7:0]    step_dx;
    logic [7:0]           step_dy;
    logic                 dir_right;
    logic                 win;
    logic                 lose;

    modport master (
        output frame_tick, run, restart, alive_count, hit_left, hit_right, hit_bottom,
        input  step_valid, step_dx, step_dy, dir_right, win, lose
    );

    modport slave (
        input  frame_tick, run, restart, alive_count, hit_left, hit_right, hit_bottom,
        output step_valid, step_dx, step_dy, dir_right, win, lose
    );

endinterface

// File: rtl/alien_march_sequencer_march_timer.sv
// Frame-tick counter; fire marks the tick on which the current interval elapses.
module alien_march_sequencer_march_timer
    import alien_march_sequencer_pkg::*;
#(
    parameter int CW = FRAME_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          en,
    input  logic          clr,
    input  logic [CW-1:0] interval,
    output logic          fire
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // >= rather than == so a shrinking interval never strands the count above it
    always_comb begin
        fire  = tick && en && !clr && (cnt_q >= (interval - CW'(1)));
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && en) begin
            cnt_d = fire ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alien_march_sequencer.sv
// Turns frame ticks into formation march steps, edge drops and win/lose.
// Optional SPEEDUP_EN: step interval tracks alive_count, clamped to [MIN_INTERVAL, BASE_INTERVAL].
module alien_march_sequencer
    import alien_march_sequencer_pkg::*;
#(
    parameter int NUM_ALIENS    = 40,
    parameter int BASE_INTERVAL = 32,
    parameter int MIN_INTERVAL  = 2,
    parameter int STEP_X        = DEF_STEP_X,
    parameter int STEP_Y        = DEF_STEP_Y
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    alien_march_sequencer_if.slave  bus
);

    localparam int AW = $clog2(NUM_ALIENS + 1);
    localparam int CW = $clog2(BASE_INTERVAL + 1);

    function automatic logic [CW-1:0] clamp_interval(input logic [AW-1:0] alive);
        int a;
        a = int'(alive);
        if (a < MIN_INTERVAL) begin
            return CW'(MIN_INTERVAL);
        end else if (a > BASE_INTERVAL) begin
            return CW'(BASE_INTERVAL);
        end
        return CW'(a);
    endfunction

    march_t            state_q, state_d;
    logic              dir_right_q, dir_right_d;
    logic              step_valid_q, step_valid_d;
    logic signed [7:0] step_dx_q, step_dx_d;
    logic [7:0]        step_dy_q, step_dy_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;

    logic [CW-1:0]     interval;
    logic              fire;
    logic              timer_en;
    logic              timer_clr;
    logic              at_edge;

`ifdef SPEEDUP_EN
    assign interval = clamp_interval(bus.alive_count);
`else
    assign interval = CW'(BASE_INTERVAL);
`endif

    assign timer_en  = (state_q == M_MARCH) && bus.run;
    assign timer_clr = bus.restart || (state_q != M_MARCH);
    assign at_edge   = (dir_right_q && bus.hit_right) || (!dir_right_q && bus.hit_left);

    alien_march_sequencer_march_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .tick     (bus.frame_tick),
        .en       (timer_en),
        .clr      (timer_clr),
        .interval (interval),
        .fire     (fire)
    );

    // restart outranks everything; a wave ending on a step tick swallows the step
    always_comb begin
        state_d      = state_q;
        dir_right_d  = dir_right_q;
        step_valid_d = 1'b0;
        step_dx_d    = '0;
        step_dy_d    = '0;
        win_d        = win_q;
        lose_d       = lose_q;
        if (bus.restart) begin
            state_d     = M_IDLE;
            dir_right_d = 1'b1;
            win_d       = 1'b0;
            lose_d      = 1'b0;
        end else begin
            case (state_q)
                M_IDLE: begin
                    if (bus.run) begin
                        state_d = M_MARCH;
                    end
                end
                M_MARCH: begin
                    if (bus.alive_count == '0) begin
                        state_d = M_DONE;
                        win_d   = 1'b1;
                    end else if (bus.hit_bottom) begin
                        state_d = M_DONE;
                        lose_d  = 1'b1;
                    end else if (fire) begin
                        step_valid_d = 1'b1;
                        if (at_edge) begin
                            step_dy_d   = 8'(STEP_Y);
                            dir_right_d = !dir_right_q;
                        end else begin
                            step_dx_d = dir_right_q ? 8'(STEP_X) : 8'(-STEP_X);
                        end
                    end
                end
                M_DONE: begin
                end
                default: begin
                    state_d = M_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= M_IDLE;
            dir_right_q  <= 1'b1;
            step_valid_q <= 1'b0;
            step_dx_q    <= '0;
            step_dy_q    <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_right_q  <= dir_right_d;
            step_valid_q <= step_valid_d;
            step_dx_q    <= step_dx_d;
            step_dy_q    <= step_dy_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
        end
    end

    assign bus.step_valid = step_valid_q;
    assign bus.step_dx    = step_dx_q;
    assign bus.step_dy    = step_dy_q;
    assign bus.dir_right  = dir_right_q;
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;

endmodule
